window3x3_gen: RTL and testbench
================================

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel width in bits, signed two's complement.
REQ-002 SHALL have parameter LINEWIDTH, default 32: pixels per image row; legal range is LINEWIDTH >= 3.
REQ-003 SHALL have parameter LNLINEWIDTH, default 5: column address width; LINEWIDTH <= 2**LNLINEWIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and in_sof are sampled only when in_valid is high.
REQ-007 SHALL have port in_sof, input, 1 bit: marks the first pixel of a frame.
REQ-008 SHALL have port in_data, input, WIDTH bits, signed: raster-order pixel stream.
REQ-009 SHALL have port out_valid, output, 1 bit: a one-cycle pulse per complete 3x3 window.
REQ-010 SHALL have port out_win, output, 9*WIDTH bits: window where element (r,c) is at out_win[WIDTH*(3r+c) +: WIDTH]; r=0 is the oldest row, c=0 is the oldest column.
REQ-011 SHALL have no backpressure port; the block accepts one pixel per cycle whenever in_valid is high.

Function
REQ-012 SHALL contain two internal row memories, lb0 (previous row) and lb1 (row before that), each LINEWIDTH x WIDTH, with 1-cycle synchronous read.
REQ-013 SHALL keep a column counter col (0..LINEWIDTH-1) and a row counter row (0..2) that saturates at 2.
REQ-014 On an accepted pixel, SHALL advance col by 1; at LINEWIDTH-1, col wraps to 0 and row increments (saturating).
REQ-015 Stage 1 on an accepted pixel SHALL read lb0[col] to rd0 and lb1[col] to rd1, write lb0[col] <= in_data, and register in_data, col, row and valid as pix_d, col_d, row_d and v_d.
REQ-016 Stage 2, when v_d=1, SHALL:
- write lb1[col_d] <= rd0;
- shift the window left one column;
- load the new column c=2 as rows 0/1/2 = rd1/rd0/pix_d.
REQ-017 SHALL set out_valid <= v_d & (row_d==2) & (col_d>=2), and clear it otherwise; out_valid is never high for two windows from one pixel.
REQ-018 Latency SHALL be exactly 2 clock edges from pixel acceptance to out_valid/out_win presenting the window whose bottom-right element is that pixel.
REQ-019 out_win SHALL hold its value when v_d=0; in_valid gaps neither shift nor corrupt the window.
REQ-020 Accepted in_sof SHALL treat the pixel as col=0, row=0, then continue counting; windows already in stage 2 still complete.
REQ-021 Windows spanning a row wrap (col_d 0 or 1) SHALL never assert out_valid.
REQ-022 Stage-2 write of lb1[col_d] and stage-1 read of lb1[col] never share an address, given LINEWIDTH >= 3; no bypass logic is required.
REQ-023 Data SHALL pass unchanged, with no arithmetic; sign is carried bit-exact.

Reset
REQ-024 While rst_n=0, SHALL clear col, row, v_d, rd0, rd1, pix_d, out_valid and out_win to 0 immediately (asynchronous).
REQ-025 Row memories SHALL NOT be reset; stale contents are masked by the row gating in REQ-017.
REQ-026 After rst_n deasserts mid-frame, the next accepted pixel SHALL be treated as col=0, row=0 whether or not in_sof is set.

Verification (WIDTH=8, LINEWIDTH=4)
REQ-027 SHALL cover: continuous 4x4 frame with values 1..16, in_sof on pixel 1 -> exactly 4 out_valid pulses.
- Windows are {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12}, {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16}.
- First pulse occurs 2 edges after pixel 11 is accepted.
REQ-028 SHALL cover: the same frame with in_valid low on every other cycle -> identical 4 windows; out_valid pulses land 2 edges after pixels 11, 12, 15 and 16.
REQ-029 SHALL cover: in_sof reasserted at pixel 7 of a frame -> no out_valid until 11 pixels after the restart; the first window is built from restart-relative pixels.
REQ-030 SHALL cover: rst_n pulsed low after pixel 10 -> out_valid=0 and out_win=0 at once; the following 16-pixel frame yields the same 4 windows as REQ-027.
REQ-031 SHALL cover: pixels -128, 127 and -1 in a 3x3 window -> those values appear in out_win bit-exact (0x80, 0x7F, 0xFF).
REQ-032 SHALL cover: 5-row frame -> row 4 produces 2 more windows whose rows 0..2 are image rows 2..4, and no window spans a column wrap.

Source files
------------

// File: rtl/window3x3_gen.sv
// Builds a 3x3 pixel window from a raster stream using two row memories; 2-edge latency
// from pixel acceptance to out_valid, one pixel per cycle, no backpressure.
module window3x3_gen #(
  parameter int WIDTH       = 8,
  parameter int LINEWIDTH   = 32,
  parameter int LNLINEWIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic [9*WIDTH-1:0]      out_win
);

  localparam logic [LNLINEWIDTH-1:0] COL_LAST = LNLINEWIDTH'(LINEWIDTH - 1);
  localparam logic [LNLINEWIDTH-1:0] COL_TWO  = LNLINEWIDTH'(2);

  // Row memories are never reset; row gating hides stale contents.
  logic [WIDTH-1:0] lb0_q [LINEWIDTH];
  logic [WIDTH-1:0] lb1_q [LINEWIDTH];

  logic [LNLINEWIDTH-1:0] col_q, col_d, col_s1_q, col_s1_d, acc_col;
  logic [1:0]             row_q, row_d, row_s1_q, row_s1_d, acc_row;
  logic                   v_s1_q, v_s1_d;
  logic [WIDTH-1:0]       pix_s1_q, pix_s1_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [9*WIDTH-1:0]     win_q, win_d;
  logic                   out_valid_q, out_valid_d;

  always_comb begin
    acc_col  = in_sof ? '0 : col_q;
    acc_row  = in_sof ? '0 : row_q;
    col_d    = col_q;
    row_d    = row_q;
    col_s1_d = col_s1_q;
    row_s1_d = row_s1_q;
    pix_s1_d = pix_s1_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    v_s1_d   = in_valid;
    if (in_valid) begin
      rd0_d    = lb0_q[acc_col];
      rd1_d    = lb1_q[acc_col];
      pix_s1_d = in_data;
      col_s1_d = acc_col;
      row_s1_d = acc_row;
      if (acc_col == COL_LAST) begin
        col_d = '0;
        row_d = (acc_row == 2'd2) ? 2'd2 : acc_row + 2'd1;
      end else begin
        col_d = acc_col + 1'b1;
        row_d = acc_row;
      end
    end
  end

  // Stage 2: shift columns left and load the new right-hand column.
  always_comb begin
    win_d       = win_q;
    out_valid_d = 1'b0;
    if (v_s1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[WIDTH*(3*r)   +: WIDTH] = win_q[WIDTH*(3*r+1) +: WIDTH];
        win_d[WIDTH*(3*r+1) +: WIDTH] = win_q[WIDTH*(3*r+2) +: WIDTH];
      end
      win_d[WIDTH*2 +: WIDTH] = rd1_q;
      win_d[WIDTH*5 +: WIDTH] = rd0_q;
      win_d[WIDTH*8 +: WIDTH] = pix_s1_q;
      out_valid_d = (row_s1_q == 2'd2) && (col_s1_q >= COL_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      col_s1_q    <= '0;
      row_s1_q    <= '0;
      v_s1_q      <= 1'b0;
      pix_s1_q    <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      col_s1_q    <= col_s1_d;
      row_s1_q    <= row_s1_d;
      v_s1_q      <= v_s1_d;
      pix_s1_q    <= pix_s1_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) lb0_q[acc_col] <= in_data;
    if (v_s1_q)   lb1_q[col_s1_q] <= rd0_q;
  end

  assign out_valid = out_valid_q;
  assign out_win   = win_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen with WIDTH=8, LINEWIDTH=4.
module tb_window3x3_gen;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_sof;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic [71:0]       out_win;

  window3x3_gen #(.WIDTH(8), .LINEWIDTH(4), .LNLINEWIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_win(out_win)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cyc    = 0;

  logic [71:0] exp_win_q [$];
  int          exp_cyc_q [$];
  logic [71:0] win_log   [$];

  // Reference image model: rolling 3-row store of the current frame.
  logic [7:0] img [3][4];
  int m_col  = 0;
  int m_rabs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_accept(input logic sof, input logic [7:0] d);
    logic [71:0] w;
    if (sof) begin
      m_col  = 0;
      m_rabs = 0;
    end
    img[m_rabs % 3][m_col] = d;
    if (m_rabs >= 2 && m_col >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[8*(3*r+c) +: 8] = img[(m_rabs-2+r) % 3][m_col-2+c];
      exp_win_q.push_back(w);
      exp_cyc_q.push_back(cyc + 2);
    end
    m_col++;
    if (m_col == 4) begin
      m_col = 0;
      m_rabs++;
    end
  endtask

  task automatic send(input logic sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    model_accept(sof, d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      logic [71:0] ew;
      int          ec;
      pulses++;
      win_log.push_back(out_win);
      checks++;
      if (exp_win_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: out_valid=1 at cycle %0d, required no window", cyc);
      end else begin
        ew = exp_win_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (out_win !== ew) begin
          errors++;
          $display("FAIL window: out_win=%h, required %h", out_win, ew);
        end
        checks++;
        if (cyc !== ec) begin
          errors++;
          $display("FAIL latency: pulse at cycle %0d, required cycle %0d", cyc, ec);
        end
      end
    end
  end

  task automatic test_reset;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b, required 0", out_valid);
    end
    checks++;
    if (out_win !== 72'h0) begin
      errors++;
      $display("FAIL reset_win: out_win=%h, required 0", out_win);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_continuous;
    int p0;
    logic [71:0] w;
    p0 = pulses;
    for (int i = 1; i <= 16; i++) send(i == 1, 8'(i));
    idle(4);
    checks++;
    if (pulses - p0 !== 4) begin
      errors++;
      $display("FAIL cont_count: pulses=%0d, required 4", pulses - p0);
    end
    w = (win_log.size() > p0) ? win_log[p0] : 72'h0;
    checks++;
    if (w !== {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL cont_first_win: out_win=%h, required window 1,2,3/5,6,7/9,10,11", w);
    end
  endtask

  task automatic test_gaps;
    int p0;
    logic [71:0] w;
    p0 = pulses;
    for (int i = 1; i <= 16; i++) begin
      send(i == 1, 8'(i));
      idle(1);
    end
    idle(4);
    checks++;
    if (pulses - p0 !== 4) begin
      errors++;
      $display("FAIL gap_count: pulses=%0d, required 4", pulses - p0);
    end
    w = (win_log.size() > p0 + 3) ? win_log[p0+3] : 72'h0;
    checks++;
    if (w !== {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6}) begin
      errors++;
      $display("FAIL gap_last_win: out_win=%h, required window 6,7,8/10,11,12/14,15,16", w);
    end
  endtask

  task automatic test_sof_restart;
    int p0;
    logic [71:0] w;
    p0 = pulses;
    for (int i = 1; i <= 6; i++) send(i == 1, 8'(i));
    for (int i = 0; i < 16; i++) send(i == 0, 8'(101 + i));
    idle(4);
    checks++;
    if (pulses - p0 !== 4) begin
      errors++;
      $display("FAIL sof_count: pulses=%0d, required 4", pulses - p0);
    end
    w = (win_log.size() > p0) ? win_log[p0] : 72'h0;
    checks++;
    if (w !== {8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105, 8'd103, 8'd102, 8'd101}) begin
      errors++;
      $display("FAIL sof_first_win: out_win=%h, required restart-relative window", w);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    logic [71:0] w;
    for (int i = 1; i <= 10; i++) send(i == 1, 8'(i));
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: out_valid=%b, required 0", out_valid);
    end
    checks++;
    if (out_win !== 72'h0) begin
      errors++;
      $display("FAIL midreset_win: out_win=%h, required 0", out_win);
    end
    exp_win_q.delete();
    exp_cyc_q.delete();
    m_col  = 0;
    m_rabs = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    p0 = pulses;
    for (int i = 1; i <= 16; i++) send(1'b0, 8'(i));
    idle(4);
    checks++;
    if (pulses - p0 !== 4) begin
      errors++;
      $display("FAIL midreset_count: pulses=%0d, required 4", pulses - p0);
    end
    w = (win_log.size() > p0) ? win_log[p0] : 72'h0;
    checks++;
    if (w !== {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL midreset_first_win: out_win=%h, required window 1,2,3/5,6,7/9,10,11", w);
    end
  endtask

  task automatic test_signed;
    int p0;
    logic [71:0] w;
    logic [7:0] pix [12];
    pix = '{8'h80, 8'h7F, 8'hFF, 8'h05, 8'h7F, 8'hFF, 8'h80, 8'h06, 8'hFF, 8'h80, 8'h7F, 8'h07};
    p0 = pulses;
    for (int i = 0; i < 12; i++) send(i == 0, pix[i]);
    idle(4);
    checks++;
    if (pulses - p0 !== 2) begin
      errors++;
      $display("FAIL signed_count: pulses=%0d, required 2", pulses - p0);
    end
    w = (win_log.size() > p0) ? win_log[p0] : 72'h0;
    checks++;
    if (w[23:0] !== 24'hFF7F80) begin
      errors++;
      $display("FAIL signed_row0: out_win[23:0]=%h, required ff7f80", w[23:0]);
    end
    checks++;
    if (w[71:48] !== 24'h7F80FF) begin
      errors++;
      $display("FAIL signed_row2: out_win[71:48]=%h, required 7f80ff", w[71:48]);
    end
  endtask

  task automatic test_five_rows;
    int p0;
    logic [71:0] w;
    p0 = pulses;
    for (int i = 1; i <= 20; i++) send(i == 1, 8'(i));
    idle(4);
    checks++;
    if (pulses - p0 !== 6) begin
      errors++;
      $display("FAIL five_count: pulses=%0d, required 6", pulses - p0);
    end
    w = (win_log.size() > p0 + 5) ? win_log[p0+5] : 72'h0;
    checks++;
    if (w !== {8'd20, 8'd19, 8'd18, 8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10}) begin
      errors++;
      $display("FAIL five_last_win: out_win=%h, required window 10,11,12/14,15,16/18,19,20", w);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses;
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 16; i++) send(i == 1, 8'(i + 32 * f));
    idle(4);
    checks++;
    if (pulses - p0 !== 8) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d, required 8", pulses - p0);
    end
    checks++;
    if (exp_win_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d expected windows never produced, required 0", exp_win_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_sof_restart();
    test_reset_mid();
    test_signed();
    test_five_rows();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
